// File: rtl/uvma_axis_pkt_sink_if.sv
// AXI-Stream bus bundle between a stream master and uvma_axis_pkt_sink.
interface uvma_axis_pkt_sink_if #(
    parameter int unsigned TDATA_WIDTH = 4,
    parameter int unsigned TID_WIDTH   = 8,
    parameter int unsigned TDEST_WIDTH = 4,
    parameter int unsigned TUSER_WIDTH = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH*8-1:0] tdata;
    logic [TDATA_WIDTH-1:0]   tstrb;
    logic [TDATA_WIDTH-1:0]   tkeep;
    logic                     tlast;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/uvma_axis_pkt_sink.sv
// AXI-Stream packet sink: LFSR backpressure, one status record per packet queued in a FIFO.
// Define UVMA_AXIS_PKT_SINK_CSUM_EN to add a 16-bit kept-byte checksum to every record.
module uvma_axis_pkt_sink #(
    parameter int unsigned TDATA_WIDTH = 4,
    parameter int unsigned TID_WIDTH   = 8,
    parameter int unsigned TDEST_WIDTH = 4,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned STS_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    uvma_axis_pkt_sink_if.slave    axis,
    input  logic                   bp_en,
    input  logic [15:0]            bp_seed,
    output logic                   sts_valid,
    input  logic                   sts_ready,
    output logic [CNT_WIDTH-1:0]   sts_beats,
    output logic [CNT_WIDTH-1:0]   sts_bytes,
    output logic [TID_WIDTH-1:0]   sts_tid,
    output logic [TDEST_WIDTH-1:0] sts_tdest,
    output logic [TUSER_WIDTH-1:0] sts_tuser,
    output logic [3:0]             sts_err,
    output logic [15:0]            sts_csum
);
    localparam int unsigned PtrW = $clog2(STS_DEPTH);

    typedef enum logic [0:0] {StIdle, StPkt} state_e;

    typedef struct packed {
        logic [CNT_WIDTH-1:0]   beats;
        logic [CNT_WIDTH-1:0]   bytes;
        logic [TID_WIDTH-1:0]   tid;
        logic [TDEST_WIDTH-1:0] tdest;
        logic [TUSER_WIDTH-1:0] tuser;
        logic [3:0]             err;
`ifdef UVMA_AXIS_PKT_SINK_CSUM_EN
        logic [15:0]            csum;
`endif
    } rec_t;

    state_e                 state_q, state_d;
    rec_t                   acc_q, acc_d;
    rec_t                   base, head;
    rec_t                   mem_q [STS_DEPTH];
    logic [15:0]            lfsr_q;
    logic [PtrW:0]          wptr_q, rptr_q;
    logic                   full, empty, hs, push, pop, first;
    logic [CNT_WIDTH:0]     keep_cnt, beats_sum, bytes_sum;
    logic [TDATA_WIDTH-1:0] keep_inc;
    logic [3:0]             beat_err;

    assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign empty = (wptr_q == rptr_q);
    // Built from registered state plus reset/bp_en only, so a master may wait on it safely.
    assign axis.tready = !reset && !full && !(bp_en && lfsr_q[0]);
    assign hs        = axis.tvalid && axis.tready;
    assign push      = hs && axis.tlast;
    assign sts_valid = !empty;
    assign pop       = sts_valid && sts_ready;
    assign first     = (state_q == StIdle);

`ifdef UVMA_AXIS_PKT_SINK_CSUM_EN
    logic [15:0] csum_add;
    always_comb begin
        csum_add = '0;
        for (int i = 0; i < TDATA_WIDTH; i++) begin
            if (axis.tkeep[i]) csum_add = csum_add + {8'h00, axis.tdata[i*8 +: 8]};
        end
    end
`else
    logic unused_tdata;
    assign unused_tdata = ^axis.tdata;
`endif

    always_comb begin
        base = first ? '0 : acc_q;
        keep_cnt = '0;
        for (int i = 0; i < TDATA_WIDTH; i++) begin
            keep_cnt = keep_cnt + {{CNT_WIDTH{1'b0}}, axis.tkeep[i]};
        end
        beats_sum = {1'b0, base.beats} + {{CNT_WIDTH{1'b0}}, 1'b1};
        bytes_sum = {1'b0, base.bytes} + keep_cnt;
        keep_inc  = axis.tkeep + TDATA_WIDTH'(1);

        // A last beat must keep a non-empty run of bytes starting at byte 0.
        beat_err[0] = axis.tlast ? ((axis.tkeep == '0) || ((axis.tkeep & keep_inc) != '0))
                                 : !(&axis.tkeep);
        beat_err[1] = !first && ((axis.tid != acc_q.tid) || (axis.tdest != acc_q.tdest));
        beat_err[2] = |(axis.tstrb & ~axis.tkeep);
        beat_err[3] = beats_sum[CNT_WIDTH] || bytes_sum[CNT_WIDTH];

        state_d = state_q;
        acc_d   = acc_q;
        if (hs) begin
            acc_d.beats = beats_sum[CNT_WIDTH] ? '1 : beats_sum[CNT_WIDTH-1:0];
            acc_d.bytes = bytes_sum[CNT_WIDTH] ? '1 : bytes_sum[CNT_WIDTH-1:0];
            acc_d.tid   = first ? axis.tid : acc_q.tid;
            acc_d.tdest = first ? axis.tdest : acc_q.tdest;
            acc_d.tuser = base.tuser | axis.tuser;
            acc_d.err   = base.err | beat_err;
`ifdef UVMA_AXIS_PKT_SINK_CSUM_EN
            acc_d.csum  = base.csum + csum_add;
`endif
            state_d = axis.tlast ? StIdle : StPkt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            lfsr_q  <= (bp_seed == 16'h0000) ? 16'h0001 : bp_seed;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            // Right-shifting form of x^16+x^14+x^13+x^11+1.
            lfsr_q  <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            if (push) wptr_q <= wptr_q + (PtrW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[PtrW-1:0]] <= acc_d;
    end

    assign head      = sts_valid ? mem_q[rptr_q[PtrW-1:0]] : '0;
    assign sts_beats = head.beats;
    assign sts_bytes = head.bytes;
    assign sts_tid   = head.tid;
    assign sts_tdest = head.tdest;
    assign sts_tuser = head.tuser;
    assign sts_err   = head.err;
`ifdef UVMA_AXIS_PKT_SINK_CSUM_EN
    assign sts_csum  = head.csum;
`else
    assign sts_csum  = 16'h0000;
`endif
endmodule

// File: tb/tb_uvma_axis_pkt_sink.sv
// Directed bench for uvma_axis_pkt_sink: a default instance and a CNT_WIDTH=4 instance.
module tb_uvma_axis_pkt_sink;
`ifdef UVMA_AXIS_PKT_SINK_CSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, bp_en, bp_en_b, sts_ready, sts_ready_b;
    logic [15:0] bp_seed;
    logic        sts_valid, sts_valid_b;
    logic [15:0] sts_beats, sts_bytes, sts_csum, sts_csum_b;
    logic [3:0]  sts_beats_b, sts_bytes_b;
    logic [7:0]  sts_tid, sts_tid_b;
    logic [3:0]  sts_tdest, sts_tdest_b, sts_err, sts_err_b;
    logic [0:0]  sts_tuser, sts_tuser_b;

    int checks = 0;
    int errors = 0;

    logic [3:0] fkeep [5] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h1};
    int         fbytes [5] = '{1, 2, 3, 4, 1};
    int         fcsum [5] = '{1, 3, 6, 10, 1};

    bit         bp_phase = 1'b0;
    int         mon_cyc = 0, mon_low = 0, mon_beats = 0, mon_recs = 0, mon_bytes = 0;
    int         mon_bad = 0, exp_bytes = 0, stall = 0;
    logic [3:0] mon_err_or = '0;
    logic [3:0] keep;

    uvma_axis_pkt_sink_if a_if ();
    uvma_axis_pkt_sink_if b_if ();

    uvma_axis_pkt_sink dut (
        .clk(clk), .reset(reset), .axis(a_if.slave), .bp_en(bp_en), .bp_seed(bp_seed),
        .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_beats(sts_beats),
        .sts_bytes(sts_bytes), .sts_tid(sts_tid), .sts_tdest(sts_tdest),
        .sts_tuser(sts_tuser), .sts_err(sts_err), .sts_csum(sts_csum)
    );

    uvma_axis_pkt_sink #(.CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .axis(b_if.slave), .bp_en(bp_en_b), .bp_seed(bp_seed),
        .sts_valid(sts_valid_b), .sts_ready(sts_ready_b), .sts_beats(sts_beats_b),
        .sts_bytes(sts_bytes_b), .sts_tid(sts_tid_b), .sts_tdest(sts_tdest_b),
        .sts_tuser(sts_tuser_b), .sts_err(sts_err_b), .sts_csum(sts_csum_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [31:0] data, input logic [3:0] kp, input logic [3:0] st,
                             input logic last, input logic [7:0] tid, input logic [3:0] tdest,
                             input logic user);
        int   n;
        logic acc;
        a_if.tdata = data; a_if.tkeep = kp; a_if.tstrb = st; a_if.tlast = last;
        a_if.tid = tid; a_if.tdest = tdest; a_if.tuser = user; a_if.tvalid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 64) begin
            #1 acc = a_if.tready;
            @(posedge clk);
            #1 n++;
        end
        a_if.tvalid = 1'b0;
        if (!acc) check("beat_timeout", 32'(acc), 32'd1);
    endtask

    task automatic pop_rec(input string tag, input int beats, input int bytes, input int tid,
                           input int tdest, input int tuser, input int err, input int csum);
        check({tag, "_valid"}, 32'(sts_valid), 32'd1);
        check({tag, "_beats"}, 32'(sts_beats), beats);
        check({tag, "_bytes"}, 32'(sts_bytes), bytes);
        check({tag, "_tid"}, 32'(sts_tid), tid);
        check({tag, "_tdest"}, 32'(sts_tdest), tdest);
        check({tag, "_tuser"}, 32'(sts_tuser), tuser);
        check({tag, "_err"}, 32'(sts_err), err);
        check({tag, "_csum"}, 32'(sts_csum), CsumEn ? csum : 0);
        sts_ready = 1'b1;
        @(posedge clk);
        #1 sts_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bp_phase) begin
            mon_cyc++;
            if (!a_if.tready) mon_low++;
            if (a_if.tvalid && a_if.tready) mon_beats++;
            if (sts_valid && sts_ready) begin
                mon_recs++;
                mon_bytes += int'(sts_bytes);
                mon_err_or |= sts_err;
                if (sts_beats != 16'd4) mon_bad++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; bp_en = 1'b0; bp_en_b = 1'b0; bp_seed = 16'hACE1;
        sts_ready = 1'b0; sts_ready_b = 1'b0;
        a_if.tvalid = 1'b0; a_if.tdata = '0; a_if.tkeep = '0; a_if.tstrb = '0;
        a_if.tlast = 1'b0; a_if.tid = '0; a_if.tdest = '0; a_if.tuser = '0;
        b_if.tvalid = 1'b0; b_if.tdata = '0; b_if.tkeep = '0; b_if.tstrb = '0;
        b_if.tlast = 1'b0; b_if.tid = '0; b_if.tdest = '0; b_if.tuser = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 32'(a_if.tready), 32'd0);
        check("rst_sts_valid", 32'(sts_valid), 32'd0);
        check("rst_sts_beats", 32'(sts_beats), 32'd0);
        check("rst_sts_err", 32'(sts_err), 32'd0);
        reset = 1'b0;
        #1 check("first_tready", 32'(a_if.tready), 32'd1);
        @(posedge clk);
        #1;

        // Three-beat packet, bytes 0x01..0x0C, last keeps two bytes.
        send_beat(32'h04030201, 4'hF, 4'hF, 1'b0, 8'd5, 4'd2, 1'b0);
        send_beat(32'h08070605, 4'hF, 4'hF, 1'b0, 8'd5, 4'd2, 1'b0);
        send_beat(32'h0C0B0A09, 4'h3, 4'h3, 1'b1, 8'd5, 4'd2, 1'b0);
        pop_rec("pkt3", 3, 10, 5, 2, 0, 0, 'h37);
        check("pkt3_drained", 32'(sts_valid), 32'd0);

        // Sixteen full beats into the 4-bit counter instance.
        b_if.tdata = 32'h01010101; b_if.tkeep = 4'hF; b_if.tstrb = 4'hF;
        b_if.tid = 8'd3; b_if.tdest = 4'd0; b_if.tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_if.tlast = (i == 15);
            #1 if (!b_if.tready) stall++;
            @(posedge clk);
            #1;
        end
        b_if.tvalid = 1'b0;
        check("sat_stalls", 32'(stall), 32'd0);
        check("sat_valid", 32'(sts_valid_b), 32'd1);
        check("sat_beats", 32'(sts_beats_b), 32'd15);
        check("sat_bytes", 32'(sts_bytes_b), 32'd15);
        check("sat_err", 32'(sts_err_b), 32'h8);
        check("sat_tid", 32'(sts_tid_b), 32'd3);
        check("sat_csum", 32'(sts_csum_b), CsumEn ? 32'h40 : 32'h0);

        // Fill the status FIFO with the consumer stalled.
        for (int k = 0; k < 4; k++)
            send_beat(32'h04030201, fkeep[k], fkeep[k], 1'b1, 8'(k + 1), 4'd0, 1'b0);
        check("full_tready", 32'(a_if.tready), 32'd0);
        a_if.tdata = 32'h04030201; a_if.tkeep = fkeep[4]; a_if.tstrb = fkeep[4];
        a_if.tlast = 1'b1; a_if.tid = 8'd5; a_if.tdest = 4'd0; a_if.tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check("full_hold", 32'(a_if.tready), 32'd0);
            @(posedge clk);
            #1;
        end
        pop_rec("fifo0", 1, fbytes[0], 1, 0, 0, 0, fcsum[0]);
        check("pop_reenable", 32'(a_if.tready), 32'd1);
        send_beat(32'h04030201, fkeep[4], fkeep[4], 1'b1, 8'd5, 4'd0, 1'b0);
        for (int k = 1; k < 5; k++)
            pop_rec($sformatf("fifo%0d", k), 1, fbytes[k], k + 1, 0, 0, 0, fcsum[k]);
        check("fifo_drained", 32'(sts_valid), 32'd0);

        // tid change mid-packet, strobe outside keep, tuser OR.
        send_beat(32'h04030201, 4'hF, 4'hF, 1'b0, 8'd7, 4'd1, 1'b0);
        send_beat(32'h04030201, 4'hF, 4'hF, 1'b0, 8'd8, 4'd1, 1'b1);
        send_beat(32'h04030201, 4'h7, 4'h8, 1'b1, 8'd7, 4'd1, 1'b0);
        pop_rec("err_id_strb", 3, 11, 7, 1, 1, 'b0110, 'h1A);
        // Partial non-last beat and non-contiguous last keep.
        send_beat(32'h04030201, 4'h3, 4'h3, 1'b0, 8'd9, 4'd3, 1'b0);
        send_beat(32'h04030201, 4'h5, 4'h5, 1'b1, 8'd9, 4'd3, 1'b0);
        pop_rec("err_keep", 2, 4, 9, 3, 0, 'b0001, 7);
        send_beat(32'h04030201, 4'h0, 4'h0, 1'b1, 8'd4, 4'd0, 1'b0);
        pop_rec("err_zero", 1, 0, 4, 0, 0, 'b0001, 0);

        // Reset with one queued record and a packet half sent.
        send_beat(32'h04030201, 4'hF, 4'hF, 1'b1, 8'h0A, 4'd4, 1'b0);
        send_beat(32'h04030201, 4'hF, 4'hF, 1'b0, 8'h0A, 4'd4, 1'b0);
        send_beat(32'h04030201, 4'hF, 4'hF, 1'b0, 8'h0A, 4'd4, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_mid_valid", 32'(sts_valid), 32'd0);
        check("rst_flush_b", 32'(sts_valid_b), 32'd0);
        send_beat(32'h04030201, 4'hF, 4'hF, 1'b0, 8'h0B, 4'd5, 1'b0);
        send_beat(32'h04030201, 4'h3, 4'h3, 1'b1, 8'h0B, 4'd5, 1'b0);
        pop_rec("after_rst", 2, 6, 'h0B, 5, 0, 0, 'h0D);

        // Backpressure: seed bit 0 is set, so tready starts low; bp_en acts combinationally.
        bp_en = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 check("bp_seed_tready", 32'(a_if.tready), 32'd0);
        bp_en = 1'b0;
        #1 check("bp_en_comb", 32'(a_if.tready), 32'd1);
        bp_en = 1'b1;
        @(posedge clk);
        #1;
        sts_ready = 1'b1;
        bp_phase = 1'b1;
        for (int p = 0; p < 250; p++) begin
            for (int bt = 0; bt < 4; bt++) begin
                keep = (bt == 3) ? fkeep[p % 4] : 4'hF;
                exp_bytes += $countones(keep);
                send_beat(32'h11223344, keep, keep, bt == 3, 8'h21, 4'd6, 1'b0);
            end
        end
        repeat (3) @(posedge clk);
        #1 bp_phase = 1'b0;
        sts_ready = 1'b0;
        check("bp_beats", 32'(mon_beats), 32'd1000);
        check("bp_recs", 32'(mon_recs), 32'd250);
        check("bp_bytes", 32'(mon_bytes), 32'(exp_bytes));
        check("bp_rec_beats", 32'(mon_bad), 32'd0);
        check("bp_errs", 32'(mon_err_or), 32'd0);
        check("bp_ratio", 32'((mon_low * 10 >= mon_cyc * 3) && (mon_low * 10 <= mon_cyc * 7)),
              32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
